// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and load/store ports, data port first.
// Optional bus watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              iport_req_i,
    input  logic [ADDR_W-1:0] iport_addr_i,
    output logic              iport_ack_o,
    output logic [31:0]       iport_data_o,
    output logic              iport_err_o,
    input  logic              dport_req_i,
    input  logic              dport_we_i,
    input  logic [2:0]        dport_width_i,
    input  logic [ADDR_W-1:0] dport_addr_i,
    input  logic [31:0]       dport_wdata_i,
    output logic              dport_ack_o,
    output logic [31:0]       dport_rdata_o,
    output logic              dport_err_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);
    localparam logic [1:0] IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2, RESP = 2'd3;
    logic [1:0]  state;
    logic        gnt_d, ld_we, resp_err, d_bad;
    logic [2:0]  ld_w;
    logic [1:0]  ld_a;
    logic [3:0]  d_sel;
    logic [31:0] resp_data, d_wdata, sh, ld_data;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
`endif
    always_comb begin
        d_bad   = (dport_width_i == 3'b011) || (dport_width_i[2:1] == 2'b11) ||
                  (dport_width_i[1:0] == 2'b01 && dport_addr_i[0]) ||
                  (dport_width_i[1:0] == 2'b10 && dport_addr_i[1:0] != 2'b00);
        d_sel   = dport_width_i[1] ? 4'b1111 :
                  ((dport_width_i[0] ? 4'b0011 : 4'b0001) << dport_addr_i[1:0]);
        d_wdata = dport_width_i[1] ? dport_wdata_i :
                  dport_width_i[0] ? {2{dport_wdata_i[15:0]}} : {4{dport_wdata_i[7:0]}};
        sh      = bus_rdata_i >> {ld_a, 3'b000};
        // width bit 2 marks the unsigned variants, which suppress sign extension
        ld_data = ld_we ? 32'h0 :
                  ld_w[1] ? sh :
                  ld_w[0] ? {{16{~ld_w[2] & sh[15]}}, sh[15:0]} :
                            {{24{~ld_w[2] & sh[7]}}, sh[7:0]};
    end
    assign iport_ack_o   = (state == RESP) && !gnt_d;
    assign dport_ack_o   = (state == RESP) && gnt_d;
    assign iport_data_o  = iport_ack_o ? resp_data : 32'h0;
    assign dport_rdata_o = dport_ack_o ? resp_data : 32'h0;
    assign iport_err_o   = iport_ack_o & resp_err;
    assign dport_err_o   = dport_ack_o & resp_err;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            gnt_d       <= 1'b0;
            ld_we       <= 1'b0;
            ld_w        <= 3'b0;
            ld_a        <= 2'b0;
            resp_data   <= 32'h0;
            resp_err    <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    resp_data <= 32'h0;
                    resp_err  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt       <= '0;
`endif
                    if (dport_req_i) begin
                        gnt_d <= 1'b1;
                        ld_we <= dport_we_i;
                        ld_w  <= dport_width_i;
                        ld_a  <= dport_addr_i[1:0];
                        if (d_bad) begin
                            resp_err <= 1'b1;
                            state    <= RESP;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= dport_we_i;
                            bus_sel_o   <= d_sel;
                            bus_addr_o  <= {dport_addr_i[ADDR_W-1:2], 2'b00};
                            bus_wdata_o <= d_wdata;
                            state       <= D_BUSY;
                        end
                    end else if (iport_req_i) begin
                        gnt_d <= 1'b0;
                        if (iport_addr_i[1:0] != 2'b00) begin
                            resp_err <= 1'b1;
                            state    <= RESP;
                        end else begin
                            bus_req_o  <= 1'b1;
                            bus_we_o   <= 1'b0;
                            bus_sel_o  <= 4'b1111;
                            bus_addr_o <= iport_addr_i;
                            state      <= I_BUSY;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (bus_ack_i) begin
                        resp_data   <= (state == I_BUSY) ? bus_rdata_i : ld_data;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'b0;
                        bus_addr_o  <= '0;
                        bus_wdata_o <= 32'h0;
                        state       <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_err    <= 1'b1;
                        bus_req_o   <= 1'b0;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'b0;
                        bus_addr_o  <= '0;
                        bus_wdata_o <= 32'h0;
                        state       <= RESP;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, lanes, load extension and errors.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst_ni = 1'b0;
    logic        iport_req = 1'b0, dport_req = 1'b0, dport_we = 1'b0, bus_ack = 1'b0;
    logic [31:0] iport_addr = '0, dport_addr = '0, dport_wdata = '0, bus_rdata = '0;
    logic [2:0]  dport_width = '0;
    logic        iport_ack, iport_err, dport_ack, dport_err, bus_req, bus_we;
    logic [31:0] iport_data, dport_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    int checks = 0, failures = 0;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .iport_req_i(iport_req), .iport_addr_i(iport_addr), .iport_ack_o(iport_ack),
        .iport_data_o(iport_data), .iport_err_o(iport_err),
        .dport_req_i(dport_req), .dport_we_i(dport_we), .dport_width_i(dport_width),
        .dport_addr_i(dport_addr), .dport_wdata_i(dport_wdata), .dport_ack_o(dport_ack),
        .dport_rdata_o(dport_rdata), .dport_err_o(dport_err),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] rd, input int dly, input bit err);
        iport_req = 1'b1; iport_addr = a;
        @(negedge clk);
        if (err) begin
            chk("i_err_noreq", 32'(bus_req), 0);
            chk("i_err_ack", 32'(iport_ack), 1);
            chk("i_err_flag", 32'(iport_err), 1);
            chk("i_err_data", iport_data, 0);
        end else begin
            chk("i_req", 32'(bus_req), 1);
            chk("i_sel", 32'(bus_sel), 32'hF);
            chk("i_we", 32'(bus_we), 0);
            chk("i_addr", bus_addr, a);
            repeat (dly) begin
                @(negedge clk);
                chk("i_hold_req", 32'(bus_req), 1);
                chk("i_no_early_ack", 32'(iport_ack), 0);
            end
            bus_ack = 1'b1; bus_rdata = rd;
            @(negedge clk);
            bus_ack = 1'b0;
            chk("i_ack", 32'(iport_ack), 1);
            chk("i_data", iport_data, rd);
            chk("i_errflag", 32'(iport_err), 0);
            chk("i_req_drop", 32'(bus_req), 0);
            chk("i_d_quiet", 32'(dport_ack), 0);
        end
        iport_req = 1'b0;
        @(negedge clk);
        chk("i_pulse", 32'(iport_ack), 0);
    endtask

    task automatic dacc(input string tag, input bit we, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input bit err,
                        input logic [3:0] e_sel, input logic [31:0] e_wd, input logic [31:0] e_rd);
        dport_req = 1'b1; dport_we = we; dport_width = w; dport_addr = a; dport_wdata = wd;
        @(negedge clk);
        if (err) begin
            chk({tag, "_noreq"}, 32'(bus_req), 0);
            chk({tag, "_ack"}, 32'(dport_ack), 1);
            chk({tag, "_err"}, 32'(dport_err), 1);
            chk({tag, "_rdata"}, dport_rdata, 0);
        end else begin
            chk({tag, "_req"}, 32'(bus_req), 1);
            chk({tag, "_we"}, 32'(bus_we), 32'(we));
            chk({tag, "_sel"}, 32'(bus_sel), 32'(e_sel));
            chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
            if (we) chk({tag, "_wdata"}, bus_wdata, e_wd);
            bus_ack = 1'b1; bus_rdata = rd;
            @(negedge clk);
            bus_ack = 1'b0;
            chk({tag, "_ack"}, 32'(dport_ack), 1);
            chk({tag, "_rdata"}, dport_rdata, e_rd);
            chk({tag, "_errflag"}, 32'(dport_err), 0);
            chk({tag, "_i_quiet"}, 32'(iport_ack), 0);
        end
        dport_req = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(dport_ack), 0);
    endtask

    initial begin
        #12;
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_iack", 32'(iport_ack), 0);
        chk("rst_dack", 32'(dport_ack), 0);
        chk("rst_sel", 32'(bus_sel), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        fetch(32'h100, 32'h00500093, 2, 1'b0);
        fetch(32'h102, 32'h0, 0, 1'b1);
        dacc("lb",  0, 3'b000, 32'h203, 0, 32'h80FF0000, 0, 4'b1000, 0, 32'hFFFFFF80);
        dacc("lbu", 0, 3'b100, 32'h203, 0, 32'h80FF0000, 0, 4'b1000, 0, 32'h00000080);
        dacc("lhu", 0, 3'b101, 32'h202, 0, 32'h80FF0000, 0, 4'b1100, 0, 32'h000080FF);
        dacc("lh",  0, 3'b001, 32'h202, 0, 32'h80FF0000, 0, 4'b1100, 0, 32'hFFFF80FF);
        dacc("lw",  0, 3'b010, 32'h200, 0, 32'h80FF0000, 0, 4'b1111, 0, 32'h80FF0000);
        dacc("lb1", 0, 3'b000, 32'h301, 0, 32'h12345678, 0, 4'b0010, 0, 32'h00000056);
        dacc("sb",  1, 3'b000, 32'h102, 32'h000000AB, 32'hDEADBEEF, 0, 4'b0100, 32'hABABABAB, 0);
        dacc("sh",  1, 3'b001, 32'h102, 32'h0000BEEF, 32'hDEADBEEF, 0, 4'b1100, 32'hBEEFBEEF, 0);
        dacc("sh_mis", 1, 3'b001, 32'h201, 32'h1234, 0, 1, 0, 0, 0);
        dacc("lw_mis", 0, 3'b010, 32'h202, 0, 0, 1, 0, 0, 0);
        dacc("w011", 0, 3'b011, 32'h200, 0, 0, 1, 0, 0, 0);
        dacc("w110", 0, 3'b110, 32'h200, 0, 0, 1, 0, 0, 0);
        // simultaneous requests: store wins, fetch held and served afterwards
        dport_req = 1'b1; dport_we = 1'b1; dport_width = 3'b010;
        dport_addr = 32'h204; dport_wdata = 32'h11223344;
        iport_req = 1'b1; iport_addr = 32'h300;
        @(negedge clk);
        chk("both_we", 32'(bus_we), 1);
        chk("both_sel", 32'(bus_sel), 32'hF);
        chk("both_addr", bus_addr, 32'h204);
        chk("both_wdata", bus_wdata, 32'h11223344);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("both_dack", 32'(dport_ack), 1);
        chk("both_iack_low", 32'(iport_ack), 0);
        dport_req = 1'b0;
        @(negedge clk);
        chk("both_idle_req", 32'(bus_req), 0);
        @(negedge clk);
        chk("both_i_req", 32'(bus_req), 1);
        chk("both_i_we", 32'(bus_we), 0);
        chk("both_i_addr", bus_addr, 32'h300);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("both_iack", 32'(iport_ack), 1);
        chk("both_idata", iport_data, 32'hCAFEF00D);
        iport_req = 1'b0;
        @(negedge clk);
        // reset while a load is on the bus
        dport_req = 1'b1; dport_we = 1'b0; dport_width = 3'b010; dport_addr = 32'h400;
        @(negedge clk);
        chk("rb_req", 32'(bus_req), 1);
        rst_ni = 1'b0;
        #1;
        chk("rb_req_drop", 32'(bus_req), 0);
        chk("rb_no_ack", 32'(dport_ack), 0);
        dport_req = 1'b0;
        @(negedge clk);
        chk("rb_no_ack2", 32'(dport_ack), 0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rb_idle", 32'(bus_req), 0);
        fetch(32'h500, 32'h13579BDF, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
